ncl_sync_tx: RTL and testbench

- Clocked transmitter that injects binary words into a dual-rail NCL pipeline as alternating DATA and NULL wavefronts.
- Uses a 4-phase, return-to-NULL handshake: it waits on the downstream completion/acknowledge signal `ko` before each transition.
- It is the producer end of the channel whose consumer side is the dual-rail completion-detecting sink. It replaces file-driven dual-rail stimulus with a synthesizable source driven from synchronous logic.

---
 rtl/ncl_sync_tx_if.sv | 36 +++
 rtl/ncl_sync_tx.sv | 119 +++++++++++
 tb/tb_ncl_sync_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ncl_sync_tx_if.sv
// Channel bundle between a synchronous word source and a dual-rail NCL pipeline.
// The master side is the transmitter; the slave side is whoever feeds it and closes the ko loop.
interface ncl_sync_tx_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 ko;
  logic [2*WIDTH-1:0]   dr_out;
  logic                 busy;
  logic [15:0]          word_count;
  logic                 err_timeout;

  modport master (
    input  in_valid,
    input  in_data,
    input  ko,
    output in_ready,
    output dr_out,
    output busy,
    output word_count,
    output err_timeout
  );

  modport slave (
    output in_valid,
    output in_data,
    output ko,
    input  in_ready,
    input  dr_out,
    input  busy,
    input  word_count,
    input  err_timeout
  );
endinterface

// File: rtl/ncl_sync_tx.sv
// Clocked producer for a dual-rail NCL channel: each accepted word goes out as a DATA
// wavefront followed by NULL, paced by a synchronized 4-phase ko handshake.
module ncl_sync_tx #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic           clk,
  input  logic           init,
  ncl_sync_tx_if.master  bus
);

  localparam int             TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TMAX   = TW'(TIMEOUT);
  localparam bit             TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_NULL = 2'd0,
    S_DATA = 2'd1,
    S_RTN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] ko_sync_q;
  logic                  ko_s;
  logic [2*WIDTH-1:0]    dr_q, dr_d;
  logic [2*WIDTH-1:0]    enc_word;
  logic [15:0]           count_q, count_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         timer_inc;
  logic                  err_q, err_d;
  logic                  hold_q, hold_d;
  logic                  ready;
  logic                  accept;

  assign ko_s = ko_sync_q[SYNC_STAGES-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
    assign enc_word[2*gi+1] = bus.in_data[gi];
    assign enc_word[2*gi]   = ~bus.in_data[gi];
  end

  // hold_q keeps in_ready low for the first cycle back in S_NULL after a return.
  assign ready     = (state_q == S_NULL) & ko_s & ~hold_q & ~init;
  assign accept    = ready & bus.in_valid;
  assign timer_inc = timer_q + 1'b1;

  always_ff @(posedge clk) begin
    if (init) begin
      state_q   <= S_NULL;
      ko_sync_q <= '0;
      dr_q      <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ko_sync_q <= {ko_sync_q[SYNC_STAGES-2:0], bus.ko};
      dr_q      <= dr_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    count_d = count_q;
    timer_d = timer_q;
    err_d   = err_q;
    hold_d  = 1'b0;

    case (state_q)
      S_NULL: begin
        timer_d = '0;
        if (accept) begin
          dr_d    = enc_word;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_inc;
        if (!ko_s) begin
          dr_d    = '0;
          state_d = S_RTN;
          timer_d = '0;
        end
      end
      S_RTN: begin
        timer_d = (timer_q == TMAX) ? timer_q : timer_inc;
        if (ko_s) begin
          state_d = S_NULL;
          count_d = count_q + 16'd1;
          timer_d = '0;
          hold_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_NULL;
        dr_d    = '0;
      end
    endcase

    // Stall flag is sticky; the handshake itself is never interrupted by it.
    if (TMO_EN && (state_q != S_NULL) && (timer_q != TMAX) && (timer_inc == TMAX)) begin
      err_d = 1'b1;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.dr_out      = dr_q;
  assign bus.busy        = (state_q != S_NULL);
  assign bus.word_count  = count_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ncl_sync_tx.sv
// Directed bench for ncl_sync_tx: scoreboarded DATA wavefronts, handshake latencies,
// stall flag, reset mid-handshake and ko low at reset exit.
module tb_ncl_sync_tx;
  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic ko_man = 1'b1;
  logic ko_auto = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rail_err = 0;
  int sent;
  int base_idx;

  logic [63:0] sb[$];
  int          data_times[$];
  logic [63:0] prev_dr = '0;

  ncl_sync_tx_if #(.WIDTH(WIDTH)) bus ();

  ncl_sync_tx #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .init(init),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Downstream model: completion seen as soon as the bus is fully DATA or fully NULL.
  assign bus.ko = ko_auto ? (bus.dr_out == '0) : ko_man;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] enc(input logic [31:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget);
    int n;
    n = 0;
    while (bus.word_count !== target && n < budget) begin
      tick();
      n++;
    end
    check("word_count_reach", 64'(bus.word_count), 64'(target));
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(bus.in_ready), 64'd1);
  endtask

  // Monitor: rail legality, and scoreboard pop on each NULL->DATA transition.
  always @(negedge clk) begin
    logic [63:0] cur;
    cur = bus.dr_out;
    for (int i = 0; i < WIDTH; i++) begin
      if (cur[2*i +: 2] == 2'b11) rail_err++;
      if (prev_dr[2*i +: 2] != 2'b00 && cur[2*i +: 2] != 2'b00 &&
          prev_dr[2*i +: 2] != cur[2*i +: 2]) rail_err++;
    end
    if (prev_dr == '0 && cur != '0) begin
      data_times.push_back(cyc);
      if (sb.size() == 0) check("sb_unexpected_data", cur, 64'd0);
      else begin
        $display("DATA cyc=%0d word=%h", cyc, cur);
        check("sb_word", cur, sb.pop_front());
      end
    end
    prev_dr = cur;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d required finish", cyc);
    $fatal(1, "bench did not finish");
  end

  initial begin
    // Reset and single-word handshake
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0001;
    init = 1'b1;
    tick();
    tick();
    check("rst_dr_out", bus.dr_out, 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_word_count", 64'(bus.word_count), 64'd0);
    check("rst_err", 64'(bus.err_timeout), 64'd0);
    init = 1'b0;
    tick();
    check("ready_lat1", 64'(bus.in_ready), 64'd0);
    tick();
    check("ready_lat2", 64'(bus.in_ready), 64'd1);
    sb.push_back(enc(bus.in_data));
    tick();
    bus.in_valid = 1'b0;
    check("first_data", bus.dr_out, 64'h5555_5555_5555_5556);
    check("first_busy", 64'(bus.busy), 64'd1);
    check("first_ready_low", 64'(bus.in_ready), 64'd0);
    ko_man = 1'b0;
    tick();
    tick();
    check("null_lat2", bus.dr_out, 64'h5555_5555_5555_5556);
    tick();
    check("null_lat3", bus.dr_out, 64'd0);
    check("rtn_busy", 64'(bus.busy), 64'd1);
    ko_man = 1'b1;
    tick();
    tick();
    check("cnt_lat2", 64'(bus.word_count), 64'd0);
    tick();
    check("cnt_lat3", 64'(bus.word_count), 64'd1);
    check("rtn_done_busy", 64'(bus.busy), 64'd0);
    check("rtn_ready_hold", 64'(bus.in_ready), 64'd0);
    tick();
    check("rtn_ready_lat4", 64'(bus.in_ready), 64'd1);

    // Ten back-to-back words with instant ko echo
    ko_auto = 1'b1;
    sent = 0;
    base_idx = data_times.size();
    bus.in_data  = 32'hA5A5_A5A5;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 400 && sent < 10; c++) begin
      if (bus.in_ready === 1'b1) begin
        sb.push_back(enc(bus.in_data));
        sent++;
        tick();
        bus.in_data = 32'hA5A5_A5A5 + 32'(sent);
        if (sent == 10) bus.in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check("burst_sent", 64'(sent), 64'd10);
    wait_count(16'd11, 100);
    if (data_times.size() >= base_idx + 10) begin
      for (int k = 1; k < 10; k++)
        check("burst_spacing", 64'(data_times[base_idx+k] - data_times[base_idx+k-1]), 64'd8);
    end else begin
      check("burst_data_events", 64'(data_times.size()), 64'(base_idx + 10));
    end

    // Stall: ko held high after DATA
    ko_auto = 1'b0;
    ko_man  = 1'b1;
    wait_ready(20);
    bus.in_data  = 32'h0F0F_1234;
    bus.in_valid = 1'b1;
    sb.push_back(enc(bus.in_data));
    tick();
    bus.in_valid = 1'b0;
    repeat (15) tick();
    check("tmo_before", 64'(bus.err_timeout), 64'd0);
    tick();
    check("tmo_at16", 64'(bus.err_timeout), 64'd1);
    ko_man = 1'b0;
    repeat (3) tick();
    check("tmo_null", bus.dr_out, 64'd0);
    check("tmo_sticky_rtn", 64'(bus.err_timeout), 64'd1);
    ko_man = 1'b1;
    wait_count(16'd12, 20);
    check("tmo_sticky_idle", 64'(bus.err_timeout), 64'd1);

    // Reset while DATA is outstanding
    wait_ready(20);
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_valid = 1'b1;
    sb.push_back(enc(bus.in_data));
    tick();
    bus.in_valid = 1'b0;
    check("ff_data", bus.dr_out, 64'hAAAA_AAAA_AAAA_AAAA);
    init = 1'b1;
    tick();
    check("midrst_dr_out", bus.dr_out, 64'd0);
    check("midrst_word_count", 64'(bus.word_count), 64'd0);
    check("midrst_err", 64'(bus.err_timeout), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    init = 1'b0;
    tick();
    check("midrst_ready_lat1", 64'(bus.in_ready), 64'd0);
    tick();
    check("midrst_ready_lat2", 64'(bus.in_ready), 64'd1);

    // ko low at reset exit with a word waiting
    init = 1'b1;
    ko_man = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1234_5678;
    tick();
    init = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("kolow_ready", 64'(bus.in_ready), 64'd0);
      check("kolow_dr_out", bus.dr_out, 64'd0);
    end
    ko_man = 1'b1;
    tick();
    check("kohigh_ready_lat1", 64'(bus.in_ready), 64'd0);
    tick();
    check("kohigh_ready_lat2", 64'(bus.in_ready), 64'd1);
    sb.push_back(enc(bus.in_data));
    tick();
    bus.in_valid = 1'b0;
    check("kohigh_data", bus.dr_out, enc(32'h1234_5678));
    ko_man = 1'b0;
    repeat (3) tick();
    check("kohigh_null", bus.dr_out, 64'd0);
    ko_man = 1'b1;
    wait_count(16'd1, 20);

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("rail_violations", 64'(rail_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
